// File: rtl/char_pkg.sv
// Shared character codes, FSM state encoding and default display word for the
// character rotator that feeds the 2-bit HEX decoders.
package char_pkg;

  localparam logic [1:0] CH_D     = 2'b00;
  localparam logic [1:0] CH_E     = 2'b01;
  localparam logic [1:0] CH_1     = 2'b10;
  localparam logic [1:0] CH_BLANK = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // "dE1" on HEX2..HEX0
  localparam logic [5:0] DEF_WORD = {CH_D, CH_E, CH_1};

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts 0..TICK_COUNT-1 while enabled and flags the
// terminal count; clear forces it back to zero.
module tick_prescaler #(
  parameter int TICK_COUNT = 50000000
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = $clog2(TICK_COUNT);
  localparam logic [CW-1:0] LAST = CW'(TICK_COUNT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (Reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tc = enable && (cnt == LAST);

endmodule

// File: rtl/char_rotator.sv
// Circular register of 2-bit character codes, rotated on a prescaled tick while
// running or by single steps while paused.
//
// state | meaning
// IDLE  | paused; prescaler held at 0, Step rotates once
// RUN   | auto-rotate on every prescaler terminal count, Step ignored
module char_rotator
  import char_pkg::*;
#(
  parameter int                    N_DISP     = 3,
  parameter int                    TICK_COUNT = 50000000,
  parameter logic [2*N_DISP-1:0]   INIT_WORD  = (2*N_DISP)'(DEF_WORD)
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic                  Load,
  input  logic [2*N_DISP-1:0]   LoadData,
  input  logic                  Run,
  input  logic                  Dir,
  input  logic                  Step,
  output logic [2*N_DISP-1:0]   Chars,
  output logic [2:0]            Pos,
  output logic                  Tick
);

  localparam int CW = 2 * N_DISP;
  localparam logic [2:0] POS_MAX = 3'(N_DISP - 1);

  state_t          state, state_nx;
  logic            rot;
  logic            tc;
  logic            pre_clear;
  logic [CW-1:0]   chars_nx;
  logic [2:0]      pos_nx;

  tick_prescaler #(
    .TICK_COUNT(TICK_COUNT)
  ) u_prescaler (
    .clk    (CLOCK_50),
    .Reset  (Reset),
    .clear  (pre_clear),
    .enable (state == RUN),
    .tc     (tc)
  );

  // Leaving RUN or loading restarts the count so no partial interval carries over
  assign pre_clear = Load || (state == IDLE) || !Run;

  always_comb begin
    state_nx = state;
    rot      = 1'b0;
    case (state)
      IDLE: begin
        rot = Step;
        if (Run) state_nx = RUN;
      end
      RUN: begin
        rot = tc;
        if (!Run) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (Load) rot = 1'b0;
  end

  always_comb begin
    if (Dir) begin
      chars_nx = {Chars[1:0], Chars[CW-1:2]};
      pos_nx   = (Pos == 3'd0) ? POS_MAX : Pos - 3'd1;
    end else begin
      chars_nx = {Chars[CW-3:0], Chars[CW-1:CW-2]};
      pos_nx   = (Pos == POS_MAX) ? 3'd0 : Pos + 3'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state <= IDLE;
      Chars <= INIT_WORD;
      Pos   <= 3'd0;
      Tick  <= 1'b0;
    end else begin
      state <= state_nx;
      Tick  <= rot;
      if (Load) begin
        Chars <= LoadData;
        Pos   <= 3'd0;
      end else if (rot) begin
        Chars <= chars_nx;
        Pos   <= pos_nx;
      end
    end
  end

endmodule
